// File: rtl/tz_slot_if.sv
`default_nettype none
// ============================================================================
//  Interface   : tz_slot_if
//  Description : Alloc/free request and status bundle for tz_slot_allocator.
//                Carries the occupancy count when TZ_ALLOC_OCCUPANCY_EN is set.
//  Revision    : 1.0  initial release
// ============================================================================
interface tz_slot_if #(
  parameter int NUM_SLOTS = 8
) ();
  localparam int IDX_W = $clog2(NUM_SLOTS);

  logic             alloc_req;
  logic             alloc_gnt;
  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_fail;
  logic             free_valid;
  logic [IDX_W-1:0] free_idx;
  logic             free_err;
  logic             full;
  logic             empty;
`ifdef TZ_ALLOC_OCCUPANCY_EN
  logic [IDX_W:0]   occupancy;

  modport master (
    output alloc_req, free_valid, free_idx,
    input  alloc_gnt, alloc_idx, alloc_fail, free_err, full, empty, occupancy
  );
  modport slave (
    input  alloc_req, free_valid, free_idx,
    output alloc_gnt, alloc_idx, alloc_fail, free_err, full, empty, occupancy
  );
`else
  modport master (
    output alloc_req, free_valid, free_idx,
    input  alloc_gnt, alloc_idx, alloc_fail, free_err, full, empty
  );
  modport slave (
    input  alloc_req, free_valid, free_idx,
    output alloc_gnt, alloc_idx, alloc_fail, free_err, full, empty
  );
`endif
endinterface
`default_nettype wire

// File: rtl/tz_slot_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tz_slot_allocator
//  Description : Lowest-index-first slot allocator over a registered busy
//                bitmap; one alloc and one free per cycle. Define
//                TZ_ALLOC_OCCUPANCY_EN to add the registered occupancy count.
//  Revision    : 1.0  initial release
// ============================================================================
module tz_slot_allocator #(
  parameter int NUM_SLOTS = 8
) (
  input  wire logic  clk,
  input  wire logic  resetn,
  tz_slot_if.slave   bus
);
  localparam int IDX_W   = $clog2(NUM_SLOTS);
  localparam int c_ext_w = 1 << IDX_W;

  logic [NUM_SLOTS-1:0] r_busy_map;
  logic [NUM_SLOTS-1:0] w_avail;
  logic [NUM_SLOTS-1:0] w_grant_mask;
  logic [NUM_SLOTS-1:0] w_free_mask;
  logic [c_ext_w-1:0]   w_busy_ext;
  logic [IDX_W-1:0]     w_sel;
  logic [IDX_W-1:0]     r_alloc_idx;
  logic                 w_any_free;
  logic                 w_alloc_ok;
  logic                 w_free_ok;
  logic                 r_alloc_gnt;
  logic                 r_alloc_fail;
  logic                 r_free_err;

  // Zero-padding the bitmap to the full index range makes out-of-range frees
  // read as "not busy", so they fall out as illegal without a separate compare.
  generate
    if (c_ext_w > NUM_SLOTS) begin : g_pad
      assign w_busy_ext = {{(c_ext_w - NUM_SLOTS){1'b0}}, r_busy_map};
    end else begin : g_nopad
      assign w_busy_ext = r_busy_map;
    end
  endgenerate

  assign w_avail    = ~r_busy_map;
  assign w_any_free = |w_avail;

  // Scan high to low so the lowest free index is the last one written.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_avail[i]) begin
        w_sel = i[IDX_W-1:0];
      end
    end
  end

  assign w_alloc_ok = bus.alloc_req & w_any_free;
  assign w_free_ok  = bus.free_valid & w_busy_ext[bus.free_idx];

  always_comb begin
    w_grant_mask = '0;
    w_free_mask  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_grant_mask[i] = w_alloc_ok & (w_sel == i[IDX_W-1:0]);
      w_free_mask[i]  = w_free_ok & (bus.free_idx == i[IDX_W-1:0]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy_map   <= '0;
      r_alloc_gnt  <= 1'b0;
      r_alloc_idx  <= '0;
      r_alloc_fail <= 1'b0;
      r_free_err   <= 1'b0;
    end else begin
      // Grant targets a free slot and free targets a busy one: masks never overlap.
      r_busy_map   <= (r_busy_map | w_grant_mask) & ~w_free_mask;
      r_alloc_gnt  <= w_alloc_ok;
      r_alloc_fail <= bus.alloc_req & ~w_any_free;
      r_free_err   <= bus.free_valid & ~w_busy_ext[bus.free_idx];
      if (w_alloc_ok) begin
        r_alloc_idx <= w_sel;
      end
    end
  end

  assign bus.alloc_gnt  = r_alloc_gnt;
  assign bus.alloc_idx  = r_alloc_idx;
  assign bus.alloc_fail = r_alloc_fail;
  assign bus.free_err   = r_free_err;
  assign bus.full       = &r_busy_map;
  assign bus.empty      = ~|r_busy_map;

`ifdef TZ_ALLOC_OCCUPANCY_EN
  logic [IDX_W:0] r_occupancy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_occupancy <= '0;
    end else begin
      case ({w_alloc_ok, w_free_ok})
        2'b10:   r_occupancy <= r_occupancy + 1'b1;
        2'b01:   r_occupancy <= r_occupancy - 1'b1;
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

  assign bus.occupancy = r_occupancy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tz_slot_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tz_slot_allocator
//  Description : Self-checking bench for tz_slot_allocator (8- and 6-slot
//                instances) against a behavioural slot-pool model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tz_slot_allocator;
  localparam int NS = 8;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  tz_slot_if #(.NUM_SLOTS(8)) bus8 ();
  tz_slot_if #(.NUM_SLOTS(6)) bus6 ();

  tz_slot_allocator #(.NUM_SLOTS(8)) u_dut8 (.clk(clk), .resetn(resetn), .bus(bus8));
  tz_slot_allocator #(.NUM_SLOTS(6)) u_dut6 (.clk(clk), .resetn(resetn), .bus(bus6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pool for the 8-slot instance
  bit m_busy[NS];
  int m_idx;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_busy[i] = 1'b0;
    m_idx = 0;
  endtask

  task automatic step8(input bit req, input bit fv, input int fi);
    int  lowest;
    int  cnt;
    bit  e_gnt;
    bit  e_fail;
    bit  e_err;
    bus8.alloc_req  = req;
    bus8.free_valid = fv;
    bus8.free_idx   = fi[2:0];
    bus6.alloc_req  = 1'b0;
    bus6.free_valid = 1'b0;
    bus6.free_idx   = '0;
    lowest = -1;
    for (int i = 0; i < NS; i++) begin
      if (!m_busy[i]) begin
        lowest = i;
        break;
      end
    end
    e_gnt  = req && (lowest >= 0);
    e_fail = req && (lowest < 0);
    e_err  = fv && !((fi < NS) && m_busy[fi]);
    @(posedge clk);
    #1;
    if (e_gnt) begin
      m_busy[lowest] = 1'b1;
      m_idx = lowest;
    end
    if (fv && !e_err) m_busy[fi] = 1'b0;
    cnt = 0;
    for (int i = 0; i < NS; i++) cnt += int'(m_busy[i]);
    check_eq("alloc_gnt", bus8.alloc_gnt, e_gnt);
    check_eq("alloc_idx", bus8.alloc_idx, m_idx);
    check_eq("alloc_fail", bus8.alloc_fail, e_fail);
    check_eq("free_err", bus8.free_err, e_err);
    check_eq("full", bus8.full, cnt == NS);
    check_eq("empty", bus8.empty, cnt == 0);
`ifdef TZ_ALLOC_OCCUPANCY_EN
    check_eq("occupancy", bus8.occupancy, cnt);
`endif
  endtask

  task automatic step6(input bit req, input bit fv, input int fi);
    bus6.alloc_req  = req;
    bus6.free_valid = fv;
    bus6.free_idx   = fi[2:0];
    bus8.alloc_req  = 1'b0;
    bus8.free_valid = 1'b0;
    bus8.free_idx   = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    bus8.alloc_req = 1'b0; bus8.free_valid = 1'b0; bus8.free_idx = '0;
    bus6.alloc_req = 1'b0; bus6.free_valid = 1'b0; bus6.free_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gnt", bus8.alloc_gnt, 0);
    check_eq("rst_idx", bus8.alloc_idx, 0);
    check_eq("rst_fail", bus8.alloc_fail, 0);
    check_eq("rst_err", bus8.free_err, 0);
    check_eq("rst_full", bus8.full, 0);
    check_eq("rst_empty", bus8.empty, 1);
    @(negedge clk);
    resetn = 1'b1;

    // Fill the pool, then one request too many
    for (int i = 0; i < NS; i++) step8(1, 0, 0);
    step8(1, 0, 0);
    // Free 5 then refill; free 2 and 6 then refill in order
    step8(0, 1, 5);
    step8(1, 0, 0);
    step8(0, 1, 2);
    step8(0, 1, 6);
    step8(1, 0, 0);
    step8(1, 0, 0);
    // Full pool: simultaneous alloc and free of 3, then alloc gets 3
    step8(1, 1, 3);
    step8(1, 0, 0);

    // 6-slot instance: out-of-range and not-busy frees, fill to full
    step6(0, 1, 7);
    check_eq("n6_err_oor", bus6.free_err, 1);
    check_eq("n6_empty", bus6.empty, 1);
    for (int i = 0; i < 6; i++) begin
      step6(1, 0, 0);
      check_eq("n6_gnt", bus6.alloc_gnt, 1);
      check_eq("n6_idx", bus6.alloc_idx, i);
    end
    check_eq("n6_full", bus6.full, 1);
    step6(1, 0, 0);
    check_eq("n6_fail", bus6.alloc_fail, 1);
    step6(0, 1, 6);
    check_eq("n6_err_6", bus6.free_err, 1);
    check_eq("n6_full_kept", bus6.full, 1);
    step6(0, 1, 5);
    check_eq("n6_err_ok", bus6.free_err, 0);
    check_eq("n6_not_full", bus6.full, 0);

    // Asynchronous reset in the middle of a grant
    model_reset();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) step8(1, 0, 0);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_gnt", bus8.alloc_gnt, 0);
    check_eq("arst_empty", bus8.empty, 1);
    check_eq("arst_full", bus8.full, 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    step8(1, 0, 0);
    step8(0, 1, 4);
    // Freeing a never-allocated slot from empty
    step8(0, 1, 0);
    step8(0, 1, 4);

    // Randomised traffic, biased towards requests so the pool saturates
    for (int n = 0; n < 1000; n++) begin
      step8($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45, int'($urandom_range(0, NS - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tz_slot_allocator.md
Name: tz_slot_allocator

Overview:
- Lowest-index-first slot allocator for a pool of NUM_SLOTS identical resources (buffer entries, tags, queue IDs).
- Holds a registered busy bitmap. The winning slot is found by a trailing-zero count on the inverted bitmap.
- One alloc request and one free request can be served per cycle.
- Sits between requesting engines and the shared pool. It is the sequencer that hands out and reclaims indices.

Parameters:
- NUM_SLOTS, 8, number of pool slots; any value >= 2, not required to be a power of two.
- IDX_W, $clog2(NUM_SLOTS), width of slot index ports (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- alloc_req  in  1  request one slot this cycle
- alloc_gnt  out  1  registered; 1 = alloc_idx valid, slot now owned by requester
- alloc_idx  out  IDX_W  registered; index granted
- alloc_fail  out  1  registered; request made while no slot free
- free_valid  in  1  release slot free_idx this cycle
- free_idx  in  IDX_W  slot being released
- free_err  out  1  registered; illegal free (slot not busy, or index out of range)
- full  out  1  combinational from bitmap: all slots busy
- empty  out  1  combinational from bitmap: no slots busy

Behaviour:
- State: busy_map[NUM_SLOTS-1:0], where 1 = allocated.
- Reset (resetn low, asynchronous): busy_map=0, alloc_gnt=0, alloc_idx=0, alloc_fail=0, free_err=0. Hence full=0 and empty=1.
- Search: avail = ~busy_map.
  - sel = number of trailing zeros of avail, i.e. the lowest-index free slot.
  - sel is only meaningful when avail != 0.
  - Bits at index >= NUM_SLOTS do not exist.
- Alloc, evaluated at each rising edge:
  - alloc_req=1 and avail!=0: busy_map[sel]<=1, alloc_gnt<=1, alloc_idx<=sel, alloc_fail<=0.
  - alloc_req=1 and avail==0: alloc_gnt<=0, alloc_fail<=1, bitmap unchanged.
  - alloc_req=0: alloc_gnt<=0, alloc_fail<=0.
  - alloc_idx holds its last value whenever alloc_gnt<=0.
- Latency: grant visible exactly 1 cycle after the request edge. No ready/backpressure: a request is either granted or failed the following cycle. The requester must not hold alloc_req high expecting one grant; each high cycle is a separate request.
- Free, evaluated at the same edge:
  - free_valid=1, free_idx<NUM_SLOTS, busy_map[free_idx]=1: busy_map[free_idx]<=0, free_err<=0.
  - free_valid=1 with the slot not busy, or free_idx>=NUM_SLOTS: no bitmap change, free_err<=1.
  - free_valid=0: free_err<=0.
- Simultaneous alloc and free in the same cycle:
  - The search uses the pre-edge bitmap.
  - The slot being freed is not grantable that cycle. It becomes grantable from the next cycle.
  - When full, alloc+free in the same cycle gives alloc_fail=1, and the free succeeds.
  - Alloc never targets a busy slot, so the alloc and free bit updates never collide.
- full=(busy_map == all ones over NUM_SLOTS). empty=(busy_map==0).
- Reset asserted mid-operation: all slots are reclaimed immediately. Any grant in flight is lost and alloc_gnt drops asynchronously.

Optional Feature:
- Macro: TZ_ALLOC_OCCUPANCY_EN.
- Defined:
  - Adds output port occupancy, width IDX_W+1, holding the registered count of busy slots (reset 0).
  - Per edge: +1 on a successful alloc, -1 on a successful free, unchanged when both or neither occur.
  - Must always equal popcount(busy_map).
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- NUM_SLOTS=8; after reset, alloc_req high for 8 consecutive cycles -> alloc_gnt=1 with alloc_idx 0,1,...,7 on successive cycles, then full=1; a 9th request -> alloc_gnt=0, alloc_fail=1.
- Pool full; free_idx=5 -> free_err=0. Next cycle alloc -> alloc_idx=5. Then free 2 and free 6, then two allocs -> alloc_idx 2 then 6.
- Pool full; alloc_req=1 with free_valid=1, free_idx=3 in the same cycle -> alloc_fail=1, slot 3 freed. Alloc the next cycle -> alloc_idx=3.
- After reset, free_idx=4 -> free_err=1, empty stays 1. With NUM_SLOTS=6, free_idx=7 -> free_err=1, bitmap unchanged.
- Allocate slots 0-2, assert resetn low mid-cycle -> alloc_gnt=0 and empty=1 immediately. After release, first alloc -> alloc_idx=0.
- TZ_ALLOC_OCCUPANCY_EN defined, random alloc/free for 1000 cycles -> occupancy equals a reference popcount every cycle, and grants always equal the lowest free index.
